// File: rtl/rv32m_divider_if.sv
// Issue/result bundle for the RV32M divide unit.
// The pipeline side drives the request (master); the divider is the slave.
interface rv32m_divider_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            start;
   logic            flush;
   logic [1:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, flush, op, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, flush, op, a, b,
      output busy, done, result
   );
endinterface

// File: rtl/rv32m_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle on operand
// magnitudes, then a sign-fix cycle. Divide-by-zero and signed overflow finish immediately.
module rv32m_divider #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 6
) (
   input logic             clk,
   input logic             rst,
   rv32m_divider_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
   logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic            sel_rem_q, sel_rem_d, done_q, done_d;

   logic            is_signed, div_zero, overflow, special;
   logic [XLEN-1:0] a_mag, b_mag, quo_fix, rem_fix;
   logic [XLEN:0]   rem_shift, trial;

   assign is_signed = ~bus.op[0];
   assign div_zero  = (bus.b == '0);
   assign overflow  = is_signed && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
   assign special   = div_zero || overflow;
   assign a_mag     = (is_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
   assign b_mag     = (is_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;

   // Shifted partial remainder is < 2*divisor, so an XLEN+1-bit difference never wraps.
   assign rem_shift = {rem_q, quo_q[XLEN-1]};
   assign trial     = rem_shift - {1'b0, dvs_q};
   assign quo_fix   = neg_quo_q ? -quo_q : quo_q;
   assign rem_fix   = neg_rem_q ? -rem_q : rem_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (bus.start && !special) state_d = StRun;
            StRun:   if (cnt_q == CNT_W'(XLEN - 1)) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      sel_rem_d = sel_rem_q;
      result_d  = result_q;
      done_d    = 1'b0;
      if (!bus.flush) begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  if (div_zero) begin
                     result_d = bus.op[1] ? bus.a : '1;
                     done_d   = 1'b1;
                  end else if (overflow) begin
                     result_d = bus.op[1] ? '0 : bus.a;
                     done_d   = 1'b1;
                  end else begin
                     cnt_d     = '0;
                     rem_d     = '0;
                     quo_d     = a_mag;
                     dvs_d     = b_mag;
                     neg_quo_d = is_signed && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                     neg_rem_d = is_signed && bus.a[XLEN-1];
                     sel_rem_d = bus.op[1];
                  end
               end
            end
            StRun: begin
               rem_d = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
               cnt_d = cnt_q + CNT_W'(1);
            end
            StFix: begin
               result_d = sel_rem_q ? rem_fix : quo_fix;
               done_d   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         sel_rem_q <= 1'b0;
         result_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         sel_rem_q <= sel_rem_d;
         result_q  <= result_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      bus.busy   = (state_q != StIdle);
      bus.done   = done_q;
      bus.result = result_q;
   end

endmodule

// File: tb/tb_rv32m_divider.sv
// Directed bench for rv32m_divider: arithmetic, special cases, handshake, flush and reset.
module tb_rv32m_divider;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   lat, nbusy, ndone;

   rv32m_divider_if #(.XLEN(32)) dif ();

   rv32m_divider #(.XLEN(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      dif.start = 1'b1;
      dif.op    = op;
      dif.a     = a;
      dif.b     = b;
      @(posedge clk);
      #1 dif.start = 1'b0;
   endtask

   // lat = index of the edge after the accepting edge whose result is visible (0 = next cycle).
   task automatic wait_done(output int l, output int nb);
      l  = 0;
      nb = 0;
      @(negedge clk);
      while (dif.done !== 1'b1 && l < 60) begin
         if (dif.busy === 1'b1) nb++;
         @(negedge clk);
         l++;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
      int l, nb;
      issue(op, a, b);
      wait_done(l, nb);
      check({tag, " latency"}, l, exp_lat);
      check({tag, " busy_cycles"}, nb, exp_lat);
      check({tag, " result"}, dif.result, exp_res);
      check({tag, " busy_at_done"}, {31'b0, dif.busy}, 32'd0);
      @(negedge clk);
      check({tag, " done_pulse"}, {31'b0, dif.done}, 32'd0);
   endtask

   task automatic count_dones(input int n, output int nd);
      nd = 0;
      repeat (n) begin
         @(negedge clk);
         if (dif.done === 1'b1) nd++;
      end
   endtask

   initial begin
      rst       = 1'b0;
      dif.start = 1'b0;
      dif.flush = 1'b0;
      dif.op    = 2'b00;
      dif.a     = '0;
      dif.b     = '0;
      #12;
      check("reset busy", {31'b0, dif.busy}, 32'd0);
      check("reset done", {31'b0, dif.done}, 32'd0);
      check("reset result", dif.result, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 33, 32'd14);
      run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 33, 32'd2);
      run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
      run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
      run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 33, 32'd1);
      run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF);
      run_op("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 33, 32'hC000_0000);
      run_op("divu_by0", 2'b01, 32'h0000_1234, 32'd0, 0, 32'hFFFF_FFFF);
      run_op("rem_by0", 2'b10, 32'h0000_1234, 32'd0, 0, 32'h0000_1234);
      run_op("div_m8_by0", 2'b00, 32'hFFFF_FFF8, 32'd0, 0, 32'hFFFF_FFFF);
      run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
      run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);

      // start while busy must be ignored
      issue(2'b01, 32'd100, 32'd7);
      lat = 0;
      @(negedge clk);
      while (dif.done !== 1'b1 && lat < 60) begin
         if (lat == 10) begin
            dif.start = 1'b1;
            dif.a     = 32'd1000;
            dif.b     = 32'd3;
            @(posedge clk);
            #1 dif.start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      check("ignore latency", lat, 33);
      check("ignore result", dif.result, 32'd14);

      // new start in the done cycle
      dif.start = 1'b1;
      dif.op    = 2'b01;
      dif.a     = 32'd200;
      dif.b     = 32'd7;
      @(posedge clk);
      #1 dif.start = 1'b0;
      wait_done(lat, nbusy);
      check("b2b latency", lat, 33);
      check("b2b result", dif.result, 32'd28);

      // flush mid-run
      issue(2'b01, 32'd1000, 32'd3);
      repeat (16) @(negedge clk);
      dif.flush = 1'b1;
      @(posedge clk);
      #1 dif.flush = 1'b0;
      @(negedge clk);
      check("flush busy", {31'b0, dif.busy}, 32'd0);
      check("flush done", {31'b0, dif.done}, 32'd0);
      check("flush result", dif.result, 32'd28);
      count_dones(40, ndone);
      check("flush no_done", ndone, 0);

      // flush beats start in idle
      @(negedge clk);
      dif.start = 1'b1;
      dif.flush = 1'b1;
      dif.a     = 32'd9;
      dif.b     = 32'd3;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      dif.flush = 1'b0;
      @(negedge clk);
      check("flush_start busy", {31'b0, dif.busy}, 32'd0);
      count_dones(40, ndone);
      check("flush_start no_done", ndone, 0);
      check("flush_start result", dif.result, 32'd28);

      // asynchronous reset mid-run
      issue(2'b01, 32'd500, 32'd5);
      repeat (21) @(negedge clk);
      rst = 1'b0;
      #1;
      check("async_rst busy", {31'b0, dif.busy}, 32'd0);
      check("async_rst done", {31'b0, dif.done}, 32'd0);
      check("async_rst result", dif.result, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      count_dones(40, ndone);
      check("async_rst no_done", ndone, 0);
      check("async_rst result_hold", dif.result, 32'd0);

      run_op("divu_500_5", 2'b01, 32'd500, 32'd5, 33, 32'd100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
